// File: rtl/ltssm_detect_ctrl.sv
// LTSSM Detect substate controller: Quiet/Active receiver-detect sequencing with lane confirmation.
// Optional `DETECT_EI_EXIT_EN lets an electrical-idle exit cut the Quiet wait short.
module ltssm_detect_ctrl #(
  parameter int unsigned TIME_VALUE_WIDTH = 3,
  parameter int unsigned NUM_LANES        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        elec_idle_exit,
  output logic                        rx_det_req,
  input  logic                        rx_det_done,
  input  logic [NUM_LANES-1:0]        rx_present,
  output logic                        timer_start,
  output logic [TIME_VALUE_WIDTH-1:0] timer_value,
  input  logic                        timeout1,
  output logic                        detect_done,
  output logic [NUM_LANES-1:0]        lanes_detected,
  output logic [2:0]                  det_state
);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StQuiet      = 3'd1,
    StActive     = 3'd2,
    StActiveWait = 3'd3,
    StActive2    = 3'd4,
    StDone       = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic                 ts_q, ts_d;
  logic                 dd_q, dd_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_d;
  logic [NUM_LANES-1:0] first_q, first_d;

  logic ei_exit;
  logic timeout_ok;
  logic det_valid;

`ifdef DETECT_EI_EXIT_EN
  assign ei_exit = elec_idle_exit;
`else
  logic unused_ei;
  assign unused_ei = elec_idle_exit;
  assign ei_exit   = 1'b0;
`endif

  // The timer flag is stale in the cycle its restart pulse is out.
  assign timeout_ok = timeout1 & ~ts_q;
  assign det_valid  = rx_det_done & req_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ts_d    = 1'b0;
    dd_d    = 1'b0;
    lanes_d = lanes_q;
    first_d = first_q;
    if (!enable) begin
      state_d = StIdle;
      req_d   = 1'b0;
      lanes_d = '0;
      first_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StQuiet;
          ts_d    = 1'b1;
          lanes_d = '0;
        end
        StQuiet: begin
          if (timeout_ok || ei_exit) begin
            state_d = StActive;
            req_d   = 1'b1;
          end
        end
        StActive: begin
          if (det_valid) begin
            req_d = 1'b0;
            if (rx_present == '0) begin
              state_d = StQuiet;
              ts_d    = 1'b1;
            end else if (&rx_present) begin
              state_d = StDone;
              dd_d    = 1'b1;
              lanes_d = rx_present;
            end else begin
              state_d = StActiveWait;
              ts_d    = 1'b1;
              first_d = rx_present;
            end
          end
        end
        StActiveWait: begin
          if (timeout_ok) begin
            state_d = StActive2;
            req_d   = 1'b1;
          end
        end
        StActive2: begin
          if (det_valid) begin
            req_d = 1'b0;
            if (rx_present == first_q) begin
              state_d = StDone;
              dd_d    = 1'b1;
              lanes_d = rx_present;
            end else begin
              state_d = StQuiet;
              ts_d    = 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
          req_d   = 1'b0;
          lanes_d = '0;
          first_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      ts_q    <= 1'b0;
      dd_q    <= 1'b0;
      lanes_q <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ts_q    <= ts_d;
      dd_q    <= dd_d;
      lanes_q <= lanes_d;
      first_q <= first_d;
    end
  end

  assign rx_det_req     = req_q;
  assign timer_start    = ts_q;
  assign timer_value    = '0;
  assign detect_done    = dd_q;
  assign lanes_detected = lanes_q;
  assign det_state      = state_q;

endmodule
